// File: rtl/multicycle_sequencer.sv
// Multicycle IF/ID/EX/MEM/WB control FSM for lw/sw/sub/xor/addi/srl/beq with PC, IR and retire counter.
// Optional: define ILLEGAL_TRAP_EN to send illegal instructions to a sticky TRAP state instead of treating them as NOPs.
module multicycle_sequencer #(
    parameter int unsigned           XLEN     = 32,
    parameter logic [XLEN-1:0]       RESET_PC = '0,
    parameter logic [XLEN-1:0]       PC_LIMIT = XLEN'(28),
    parameter int unsigned           RET_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      instr_in,
    input  logic             alu_zero,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      instr_q,
    output logic [2:0]       state,
    output logic             ir_load,
    output logic             pc_write,
    output logic             regiwrite,
    output logic             memread,
    output logic             memwrite,
    output logic [1:0]       aluop,
    output logic [3:0]       alucontrol,
    output logic             done,
    output logic             trap,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EX   = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_TRAP = 3'b101,
        S_FIM  = 3'b110,
        S_IDLE = 3'b111
    } state_t;

    state_t           r_state, w_next;
    logic [XLEN-1:0]  r_pc, r_old_pc, w_pc_new;
    logic [31:0]      r_ir;
    logic [RET_W-1:0] r_retired;
    logic             w_last;

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_is_sub, w_is_xor, w_is_srl, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_legal;
    logic [XLEN-1:0] w_imm_b;

    assign w_op      = r_ir[6:0];
    assign w_f3      = r_ir[14:12];
    assign w_f7      = r_ir[31:25];
    assign w_is_sub  = (w_op == 7'b0110011) && (w_f7 == 7'b0100000) && (w_f3 == 3'b000);
    assign w_is_xor  = (w_op == 7'b0110011) && (w_f7 == 7'b0000000) && (w_f3 == 3'b100);
    assign w_is_srl  = (w_op == 7'b0110011) && (w_f7 == 7'b0000000) && (w_f3 == 3'b101);
    assign w_is_addi = (w_op == 7'b0010011) && (w_f3 == 3'b000);
    assign w_is_lw   = (w_op == 7'b0000011) && (w_f3 == 3'b010);
    assign w_is_sw   = (w_op == 7'b0100011) && (w_f3 == 3'b010);
    assign w_is_beq  = (w_op == 7'b1100011) && (w_f3 == 3'b000);
    assign w_legal   = w_is_sub | w_is_xor | w_is_srl | w_is_addi | w_is_lw | w_is_sw | w_is_beq;
    assign w_imm_b   = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

    always_comb begin
        w_next     = r_state;
        w_pc_new   = r_pc;
        w_last     = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        regiwrite  = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        aluop      = 2'b00;
        alucontrol = 4'b0000;
        done       = 1'b0;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_IF;
            S_IF: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                w_pc_new = r_pc + XLEN'(4);
                w_next   = S_ID;
            end
            S_ID: begin
                if (w_legal) begin
                    w_next = S_EX;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_last = 1'b1;
`endif
                end
            end
            S_EX: begin
                if (w_is_beq) begin
                    aluop      = 2'b01;
                    alucontrol = 4'b0110;
                    w_last     = 1'b1;
                    if (alu_zero) begin
                        pc_write = 1'b1;
                        w_pc_new = r_old_pc + w_imm_b;
                    end
                end else if (w_is_lw || w_is_sw) begin
                    aluop      = 2'b00;
                    alucontrol = 4'b0010;
                    w_next     = S_MEM;
                end else begin
                    aluop      = 2'b10;
                    alucontrol = w_is_sub ? 4'b0110 :
                                 w_is_xor ? 4'b0011 :
                                 w_is_srl ? 4'b0101 : 4'b0010;
                    w_next     = S_WB;
                end
            end
            S_MEM: begin
                memread  = w_is_lw;
                memwrite = w_is_sw;
                if (w_is_sw) w_last = 1'b1;
                else         w_next = S_WB;
            end
            S_WB: begin
                regiwrite = 1'b1;
                w_last    = 1'b1;
            end
            S_FIM:  done = 1'b1;
            S_TRAP: ;
            default: ;
        endcase
        // Halt decision uses the post-instruction PC, so a taken branch target counts.
        if (w_last) w_next = (w_pc_new >= PC_LIMIT) ? S_FIM : S_IF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_old_pc  <= RESET_PC;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_new;
            if (r_state == S_IF) begin
                r_ir     <= instr_in;
                r_old_pc <= r_pc;
            end
            if (w_last) r_retired <= r_retired + RET_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign trap = (r_state == S_TRAP);
`else
    assign trap = 1'b0;
`endif

    assign pc      = r_pc;
    assign instr_q = r_ir;
    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: per-instruction reference model of state path, strobes, PC and retire count.
// Honours ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_sequencer;

    localparam int LIMIT = 100;

    logic        clk = 1'b0;
    logic        reset, start, alu_zero;
    logic [31:0] instr_in, pc, instr_q;
    logic [2:0]  state;
    logic        ir_load, pc_write, regiwrite, memread, memwrite, done, trap;
    logic [1:0]  aluop;
    logic [3:0]  alucontrol;
    logic [15:0] retired;

    multicycle_sequencer #(
        .XLEN(32), .RESET_PC(32'h0), .PC_LIMIT(32'd100), .RET_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .instr_in(instr_in), .alu_zero(alu_zero),
        .pc(pc), .instr_q(instr_q), .state(state), .ir_load(ir_load), .pc_write(pc_write),
        .regiwrite(regiwrite), .memread(memread), .memwrite(memwrite), .aluop(aluop),
        .alucontrol(alucontrol), .done(done), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [64];
    logic [31:0] tgt_of [64];
    assign instr_in = imem[pc[7:2]];

    typedef enum {K_SUB, K_XOR, K_SRL, K_ADDI, K_LW, K_SW, K_BEQ, K_ILL} kind_t;

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] m_pc;
    logic [15:0] m_ret;
    bit          trapped;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic kind_t classify(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) return K_SUB;
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd4) return K_XOR;
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd5) return K_SRL;
        if (op == 7'h13 && f3 == 3'd0) return K_ADDI;
        if (op == 7'h03 && f3 == 3'd2) return K_LW;
        if (op == 7'h23 && f3 == 3'd2) return K_SW;
        if (op == 7'h63 && f3 == 3'd0) return K_BEQ;
        return K_ILL;
    endfunction

    // {ir_load, pc_write, regiwrite, memread, memwrite, aluop, alucontrol, done, trap}
    function automatic logic [12:0] exp_strobes(input int st, input kind_t k, input bit z);
        logic [1:0] op = 2'b00;
        logic [3:0] ctl = 4'b0000;
        case (st)
            0: return 13'b1_1_0_0_0_00_0000_0_0;
            2: begin
                case (k)
                    K_LW, K_SW: begin op = 2'b00; ctl = 4'b0010; end
                    K_BEQ:      begin op = 2'b01; ctl = 4'b0110; end
                    K_SUB:      begin op = 2'b10; ctl = 4'b0110; end
                    K_XOR:      begin op = 2'b10; ctl = 4'b0011; end
                    K_SRL:      begin op = 2'b10; ctl = 4'b0101; end
                    default:    begin op = 2'b10; ctl = 4'b0010; end
                endcase
                return {1'b0, (k == K_BEQ) && z, 3'b000, op, ctl, 2'b00};
            end
            3: return {3'b000, k == K_LW, k == K_SW, 8'h00};
            4: return 13'b0_0_1_0_0_00_0000_0_0;
            5: return 13'b0_0_0_0_0_00_0000_0_1;
            6: return 13'b0_0_0_0_0_00_0000_1_0;
            default: return '0;
        endcase
    endfunction

    function automatic logic [12:0] obs_strobes();
        return {ir_load, pc_write, regiwrite, memread, memwrite, aluop, alucontrol, done, trap};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h33};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [12:0] b);
        return {b[12], b[10:5], 5'($urandom), 5'($urandom), 3'b000, b[4:1], b[11], 7'h63};
    endfunction

    task automatic gen_program(input bit all_addi);
        logic [31:0] off;
        logic [11:0] imm;
        for (int i = 0; i < 64; i++) begin
            imm = 12'($urandom);
            tgt_of[i] = 0;
            case (all_addi ? 3 : $urandom_range(0, 7))
                0: imem[i] = enc_r(7'h20, 3'd0);
                1: imem[i] = enc_r(7'h00, 3'd4);
                2: imem[i] = enc_r(7'h00, 3'd5);
                3: imem[i] = {imm, 5'($urandom), 3'd0, 5'($urandom), 7'h13};
                4: imem[i] = {imm, 5'($urandom), 3'd2, 5'($urandom), 7'h03};
                5: imem[i] = {imm[11:5], 5'($urandom), 5'($urandom), 3'd2, imm[4:0], 7'h23};
                6: begin
                    tgt_of[i] = 4 * $urandom_range(0, LIMIT / 4 + 1);
                    off = tgt_of[i] - 32'(4 * i);
                    imem[i] = enc_beq(off[12:0]);
                end
                default: imem[i] = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : enc_r(7'h00, 3'd0);
            endcase
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; alu_zero = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_state", 32'(state), 32'd7);
        check("rst_pc", pc, 32'h0);
        check("rst_ir", instr_q, 32'h0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_strobes", 32'(obs_strobes()), 32'd0);
        m_pc = 0; m_ret = 0; trapped = 0;
    endtask

    task automatic kick();
        @(posedge clk); #1;
        check("idle_hold", 32'(state), 32'd7);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_insn();
        logic [31:0] w;
        int          idx, seq[$];
        kind_t       k;
        bit          z;
        idx = int'(m_pc[7:2]);
        w   = imem[idx];
        k   = classify(w);
        z   = 1'($urandom_range(0, 1));
        alu_zero = z;
        seq = {0, 1};
        case (k)
            K_LW:  seq = {seq, 2, 3, 4};
            K_SW:  seq = {seq, 2, 3};
            K_BEQ: seq = {seq, 2};
            K_ILL: ;
            default: seq = {seq, 2, 4};
        endcase
        foreach (seq[j]) begin
            check("state", 32'(state), 32'(seq[j]));
            check("strobes", 32'(obs_strobes()), 32'(exp_strobes(seq[j], k, z)));
            if (j == 0) check("pc_if", pc, m_pc);
            else        check("ir", instr_q, w);
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        if (k == K_ILL) begin
            check("trap_state", 32'(state), 32'd5);
            check("trap_strobes", 32'(obs_strobes()), 32'(exp_strobes(5, k, z)));
            check("trap_pc", pc, m_pc + 4);
            check("trap_retired", 32'(retired), 32'(m_ret));
            trapped = 1;
            return;
        end
`endif
        m_pc  = (k == K_BEQ && z) ? tgt_of[idx] : m_pc + 4;
        m_ret = m_ret + 1;
        check("pc_after", pc, m_pc);
        check("retired", 32'(retired), 32'(m_ret));
        check("next_state", 32'(state), (m_pc >= LIMIT) ? 32'd6 : 32'd0);
    endtask

    task automatic run_program(input int max_insn);
        do_reset();
        kick();
        for (int i = 0; i < max_insn && !trapped && m_pc < LIMIT; i++) run_insn();
        if (!trapped && m_pc >= LIMIT) begin
            for (int c = 0; c < 3; c++) begin
                start = 1'b1;
                @(posedge clk); #1;
                check("fim_state", 32'(state), 32'd6);
                check("fim_done", 32'(obs_strobes()), 32'(exp_strobes(6, K_ADDI, 1'b0)));
                check("fim_pc", pc, m_pc);
            end
            start = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; alu_zero = 1'b0;
        gen_program(1'b0);
        imem[0] = 32'h402081B3;
        imem[1] = 32'h00802283;
        imem[2] = 32'hFE000CE3; tgt_of[2] = 0;
        imem[3] = 32'h00502623;
        imem[4] = 32'hFFFF_FFFF;
        run_program(12);

        // Abort during MEM of lw after one retired instruction.
        do_reset();
        kick();
        imem[0] = 32'h402081B3;
        imem[1] = 32'h00802283;
        run_insn();
        for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
        check("mid_mem_state", 32'(state), 32'd3);
        check("mid_memread", 32'(memread), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_state", 32'(state), 32'd7);
        check("abort_pc", pc, 32'h0);
        check("abort_retired", 32'(retired), 32'd0);
        check("abort_strobes", 32'(obs_strobes()), 32'd0);

        gen_program(1'b1);
        run_program(40);

        for (int p = 0; p < 20; p++) begin
            gen_program(1'b0);
            run_program(40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
